// File: rtl/nfc_cmd_regfile_if.sv
// AXI4-Lite bus bundle for the NFC command/status register file.
interface nfc_cmd_regfile_if #(
  parameter int AXI_ADDR_WIDTH = 7,
  parameter int AXI_DATA_WIDTH = 32
);
  logic [AXI_ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]                  awprot;
  logic                        awvalid;
  logic                        awready;
  logic [AXI_DATA_WIDTH-1:0]   wdata;
  logic [AXI_DATA_WIDTH/8-1:0] wstrb;
  logic                        wvalid;
  logic                        wready;
  logic [1:0]                  bresp;
  logic                        bvalid;
  logic                        bready;
  logic [AXI_ADDR_WIDTH-1:0]   araddr;
  logic [2:0]                  arprot;
  logic                        arvalid;
  logic                        arready;
  logic [AXI_DATA_WIDTH-1:0]   rdata;
  logic [1:0]                  rresp;
  logic                        rvalid;
  logic                        rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/nfc_cmd_regfile.sv
// NFC command staging registers, doorbell-fed command FIFO and per-channel status readback.
// Optional interrupt block enabled by defining NFC_CMD_IRQ_EN.
module nfc_cmd_regfile #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 7,
  parameter int NUM_CH         = 4,
  parameter int CMD_DEPTH      = 4,
  localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  S_AXI_ACLK,
  input  logic                  S_AXI_ARESETN,
  nfc_cmd_regfile_if.slave      s_axi,
  output logic                  nfc_cmd_valid,
  input  logic                  nfc_cmd_ready,
  output logic [15:0]           nfc_cmd_opcode,
  output logic [23:0]           nfc_cmd_len,
  output logic [47:0]           nfc_cmd_lba,
  output logic [CH_W-1:0]       nfc_cmd_ch,
  input  logic [NUM_CH*8-1:0]   o_sr,
  input  logic [NUM_CH*2-1:0]   o_status
`ifdef NFC_CMD_IRQ_EN
  ,
  output logic                  irq
`endif
);
  // state  | meaning
  // W_IDLE | waiting for AW and W together
  // W_ACK  | AWREADY/WREADY high, register update and push at end of cycle
  // W_RESP | BVALID held until BREADY
  // R_IDLE | waiting for AR
  // R_ACK  | ARREADY high, read data captured at end of cycle
  // R_DATA | RVALID held until RREADY

  localparam int WA    = AXI_ADDR_WIDTH - 2;
  localparam int PW    = $clog2(CMD_DEPTH);
  localparam int CW    = PW + 1;
  localparam int ENT_W = CH_W + 88;

  localparam logic [WA-1:0] A_OPCODE   = WA'(0);
  localparam logic [WA-1:0] A_LEN      = WA'(1);
  localparam logic [WA-1:0] A_LBA_LO   = WA'(2);
  localparam logic [WA-1:0] A_LBA_HI   = WA'(3);
  localparam logic [WA-1:0] A_DOORBELL = WA'(4);
  localparam logic [WA-1:0] A_FSTAT    = WA'(5);
`ifdef NFC_CMD_IRQ_EN
  localparam logic [WA-1:0] A_IRQ_STAT = WA'(6);
  localparam logic [WA-1:0] A_IRQ_MASK = WA'(7);
`endif
  localparam logic [WA-1:0] A_CH0      = WA'(16);
  localparam logic [WA-1:0] A_CH_END   = WA'(16 + NUM_CH);

  typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ACK, R_DATA} rd_state_t;

  wr_state_t wr_q, wr_nxt;
  rd_state_t rd_q, rd_nxt;

  logic [15:0]               opcode_q;
  logic [23:0]               len_q;
  logic [31:0]               lba_lo_q;
  logic [15:0]               lba_hi_q;
  logic                      ovf_q;
  logic [1:0]                bresp_q;
  logic [1:0]                rresp_q;
  logic [AXI_DATA_WIDTH-1:0] rdata_q;
  logic [NUM_CH*8-1:0]       sr_q;
  logic [NUM_CH*2-1:0]       st_q;

  logic [ENT_W-1:0] mem [CMD_DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic [ENT_W-1:0] head, push_ent;

  logic [WA-1:0]             waddr, raddr;
  logic [AXI_DATA_WIDTH-1:0] wmask;
  logic [AXI_DATA_WIDTH-1:0] rd_data;
  logic                      rd_err;
  logic wr_en, wr_hit, wr_err, db_req, db_ch_bad, push, pop, ovf_evt, full, empty;

`ifdef NFC_CMD_IRQ_EN
  logic [1:0] irq_stat_q, irq_mask_q, irq_stat_nxt, irq_mask_nxt;
`endif

  logic unused_bits;
  assign unused_bits = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0], s_axi.araddr[1:0]};

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      wr_q <= W_IDLE;
      rd_q <= R_IDLE;
    end else begin
      wr_q <= wr_nxt;
      rd_q <= rd_nxt;
    end
  end

  always_comb begin
    wr_nxt = wr_q;
    case (wr_q)
      W_IDLE:  if (s_axi.awvalid && s_axi.wvalid) wr_nxt = W_ACK;
      W_ACK:   wr_nxt = W_RESP;
      W_RESP:  if (s_axi.bready) wr_nxt = W_IDLE;
      default: wr_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    rd_nxt = rd_q;
    case (rd_q)
      R_IDLE:  if (s_axi.arvalid) rd_nxt = R_ACK;
      R_ACK:   rd_nxt = R_DATA;
      R_DATA:  if (s_axi.rready) rd_nxt = R_IDLE;
      default: rd_nxt = R_IDLE;
    endcase
  end

  assign s_axi.awready = (wr_q == W_ACK);
  assign s_axi.wready  = (wr_q == W_ACK);
  assign s_axi.bvalid  = (wr_q == W_RESP);
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = (rd_q == R_ACK);
  assign s_axi.rvalid  = (rd_q == R_DATA);
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;

  assign waddr = s_axi.awaddr[AXI_ADDR_WIDTH-1:2];
  assign raddr = s_axi.araddr[AXI_ADDR_WIDTH-1:2];
  assign wr_en = (wr_q == W_ACK);

  always_comb begin
    wmask = '0;
    for (int b = 0; b < AXI_DATA_WIDTH/8; b++) wmask[8*b +: 8] = {8{s_axi.wstrb[b]}};
  end

  always_comb begin
    wr_hit = 1'b0;
    case (waddr)
      A_OPCODE, A_LEN, A_LBA_LO, A_LBA_HI, A_DOORBELL, A_FSTAT: wr_hit = 1'b1;
`ifdef NFC_CMD_IRQ_EN
      A_IRQ_STAT, A_IRQ_MASK: wr_hit = 1'b1;
`endif
      default: wr_hit = (waddr >= A_CH0) && (waddr < A_CH_END);
    endcase
  end

  assign full  = (count == CW'(CMD_DEPTH));
  assign empty = (count == '0);

  // Channel range is checked on the whole byte so out-of-range numbers cannot alias onto a valid channel.
  assign db_req    = (waddr == A_DOORBELL) && s_axi.wstrb[0] && s_axi.wdata[0];
  assign db_ch_bad = (s_axi.wdata[15:8] >= 8'(NUM_CH));
  assign push      = wr_en && db_req && !db_ch_bad && !full;
  assign ovf_evt   = wr_en && db_req && !db_ch_bad && full;
  assign pop       = nfc_cmd_valid && nfc_cmd_ready;
  assign wr_err    = !wr_hit || (db_req && (db_ch_bad || full));
  assign push_ent  = {s_axi.wdata[8 +: CH_W], lba_hi_q, lba_lo_q, len_q, opcode_q};

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      opcode_q <= '0;
      len_q    <= '0;
      lba_lo_q <= '0;
      lba_hi_q <= '0;
      ovf_q    <= 1'b0;
      bresp_q  <= 2'b00;
      rresp_q  <= 2'b00;
      rdata_q  <= '0;
      sr_q     <= '0;
      st_q     <= '0;
    end else begin
      sr_q <= o_sr;
      st_q <= o_status;
      if (wr_en) begin
        bresp_q <= wr_err ? 2'b10 : 2'b00;
        if (waddr == A_OPCODE) opcode_q <= (opcode_q & ~wmask[15:0]) | (s_axi.wdata[15:0] & wmask[15:0]);
        if (waddr == A_LEN)    len_q    <= (len_q & ~wmask[23:0]) | (s_axi.wdata[23:0] & wmask[23:0]);
        if (waddr == A_LBA_LO) lba_lo_q <= (lba_lo_q & ~wmask[31:0]) | (s_axi.wdata[31:0] & wmask[31:0]);
        if (waddr == A_LBA_HI) lba_hi_q <= (lba_hi_q & ~wmask[15:0]) | (s_axi.wdata[15:0] & wmask[15:0]);
      end
      if (ovf_evt) ovf_q <= 1'b1;
      else if (wr_en && (waddr == A_FSTAT) && s_axi.wstrb[2] && s_axi.wdata[16]) ovf_q <= 1'b0;
      if (rd_q == R_ACK) begin
        rdata_q <= rd_data;
        rresp_q <= rd_err ? 2'b10 : 2'b00;
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < CMD_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_ent;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head           = mem[rd_ptr];
  assign nfc_cmd_valid  = !empty;
  assign nfc_cmd_opcode = head[15:0];
  assign nfc_cmd_len    = head[39:16];
  assign nfc_cmd_lba    = head[87:40];
  assign nfc_cmd_ch     = head[88 +: CH_W];

  always_comb begin
    rd_data = 32'hDEAD_BEEF;
    rd_err  = 1'b1;
    case (raddr)
      A_OPCODE:   begin rd_data = {16'b0, opcode_q}; rd_err = 1'b0; end
      A_LEN:      begin rd_data = {8'b0, len_q};     rd_err = 1'b0; end
      A_LBA_LO:   begin rd_data = lba_lo_q;          rd_err = 1'b0; end
      A_LBA_HI:   begin rd_data = {16'b0, lba_hi_q}; rd_err = 1'b0; end
      A_DOORBELL: begin rd_data = '0;                rd_err = 1'b0; end
      A_FSTAT: begin
        rd_data = {15'b0, ovf_q, 6'b0, full, empty, 8'(count)};
        rd_err  = 1'b0;
      end
`ifdef NFC_CMD_IRQ_EN
      A_IRQ_STAT: begin rd_data = {30'b0, irq_stat_q}; rd_err = 1'b0; end
      A_IRQ_MASK: begin rd_data = {30'b0, irq_mask_q}; rd_err = 1'b0; end
`endif
      default: ;
    endcase
    for (int c = 0; c < NUM_CH; c++) begin
      if (raddr == A_CH0 + WA'(c)) begin
        rd_data = {22'b0, st_q[2*c +: 2], sr_q[8*c +: 8]};
        rd_err  = 1'b0;
      end
    end
  end

`ifdef NFC_CMD_IRQ_EN
  // Sets are applied after the W1C clear so a same-cycle event is never lost.
  always_comb begin
    irq_stat_nxt = irq_stat_q;
    irq_mask_nxt = irq_mask_q;
    if (wr_en && (waddr == A_IRQ_STAT) && s_axi.wstrb[0]) irq_stat_nxt = irq_stat_q & ~s_axi.wdata[1:0];
    if (wr_en && (waddr == A_IRQ_MASK) && s_axi.wstrb[0]) irq_mask_nxt = s_axi.wdata[1:0];
    if (pop && !push && (count == CW'(1))) irq_stat_nxt[0] = 1'b1;
    if (ovf_evt) irq_stat_nxt[1] = 1'b1;
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      irq_stat_q <= 2'b00;
      irq_mask_q <= 2'b00;
      irq        <= 1'b0;
    end else begin
      irq_stat_q <= irq_stat_nxt;
      irq_mask_q <= irq_mask_nxt;
      irq        <= |(irq_stat_nxt & irq_mask_nxt);
    end
  end
`endif

endmodule

// File: tb/tb_nfc_cmd_regfile.sv
// Directed self-checking bench for nfc_cmd_regfile; IRQ checks compile in with NFC_CMD_IRQ_EN.
module tb_nfc_cmd_regfile;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  nfc_cmd_regfile_if #(.AXI_ADDR_WIDTH(7), .AXI_DATA_WIDTH(32)) axi ();

  logic        nfc_cmd_valid;
  logic        nfc_cmd_ready;
  logic [15:0] nfc_cmd_opcode;
  logic [23:0] nfc_cmd_len;
  logic [47:0] nfc_cmd_lba;
  logic [1:0]  nfc_cmd_ch;
  logic [31:0] o_sr;
  logic [7:0]  o_status;
`ifdef NFC_CMD_IRQ_EN
  logic        irq;
`endif

  nfc_cmd_regfile #(
    .AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(7), .NUM_CH(4), .CMD_DEPTH(4)
  ) dut (
    .S_AXI_ACLK     (clk),
    .S_AXI_ARESETN  (rst_n),
    .s_axi          (axi),
    .nfc_cmd_valid  (nfc_cmd_valid),
    .nfc_cmd_ready  (nfc_cmd_ready),
    .nfc_cmd_opcode (nfc_cmd_opcode),
    .nfc_cmd_len    (nfc_cmd_len),
    .nfc_cmd_lba    (nfc_cmd_lba),
    .nfc_cmd_ch     (nfc_cmd_ch),
    .o_sr           (o_sr),
    .o_status       (o_status)
`ifdef NFC_CMD_IRQ_EN
    ,
    .irq            (irq)
`endif
  );

  int   total = 0;
  int   bad   = 0;
  logic valid_at_b;
  logic pop_on_push;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input string tag, input logic [6:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [1:0] er, input int hold);
    int n;
    axi.awaddr = a; axi.wdata = d; axi.wstrb = s;
    axi.awvalid = 1'b1; axi.wvalid = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (axi.awready !== 1'b1 && n < 20);
    chk({tag, "_awready"}, axi.awready, 1);
    if (pop_on_push) nfc_cmd_ready = 1'b1;
    @(posedge clk); #1;
    if (pop_on_push) nfc_cmd_ready = 1'b0;
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    n = 0;
    while (axi.bvalid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    chk({tag, "_bvalid"}, axi.bvalid, 1);
    chk({tag, "_bresp"}, axi.bresp, er);
    valid_at_b = nfc_cmd_valid;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_bvalid_hold"}, axi.bvalid, 1);
      chk({tag, "_bresp_hold"}, axi.bresp, er);
    end
    axi.bready = 1'b1;
    @(posedge clk); #1;
    axi.bready = 1'b0;
  endtask

  task automatic axi_read(input string tag, input logic [6:0] a, input logic [31:0] ed,
                          input logic [1:0] er, input int hold);
    int n;
    axi.araddr = a; axi.arvalid = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (axi.arready !== 1'b1 && n < 20);
    chk({tag, "_arready"}, axi.arready, 1);
    @(posedge clk); #1;
    axi.arvalid = 1'b0;
    n = 0;
    while (axi.rvalid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    chk({tag, "_rvalid"}, axi.rvalid, 1);
    chk({tag, "_rdata"}, axi.rdata, ed);
    chk({tag, "_rresp"}, axi.rresp, er);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_rvalid_hold"}, axi.rvalid, 1);
      chk({tag, "_rdata_hold"}, axi.rdata, ed);
      chk({tag, "_rresp_hold"}, axi.rresp, er);
    end
    axi.rready = 1'b1;
    @(posedge clk); #1;
    axi.rready = 1'b0;
  endtask

  task automatic pop_one();
    nfc_cmd_ready = 1'b1;
    @(posedge clk); #1;
    nfc_cmd_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    axi.awaddr = '0; axi.awprot = '0; axi.awvalid = 1'b0;
    axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0; axi.bready = 1'b0;
    axi.araddr = '0; axi.arprot = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;
    nfc_cmd_ready = 1'b0; o_sr = '0; o_status = '0;
    pop_on_push = 1'b0; valid_at_b = 1'b0;

    // reset state
    repeat (3) @(posedge clk); #1;
    chk("rst_awready", axi.awready, 0);
    chk("rst_wready", axi.wready, 0);
    chk("rst_bvalid", axi.bvalid, 0);
    chk("rst_arready", axi.arready, 0);
    chk("rst_rvalid", axi.rvalid, 0);
    chk("rst_cmd_valid", nfc_cmd_valid, 0);
    chk("rst_cmd_lba", nfc_cmd_lba, 0);
`ifdef NFC_CMD_IRQ_EN
    chk("rst_irq", irq, 0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;
    axi_read("rst_fstat", 7'h14, 32'h0000_0100, 2'b00, 0);
    axi_read("rst_opcode", 7'h00, 32'h0, 2'b00, 0);

    // stage a command and ring the doorbell for channel 2
    axi_write("wr_opc", 7'h00, 32'h0000_0030, 4'hF, 2'b00, 0);
    axi_write("wr_len", 7'h04, 32'h0000_1000, 4'hF, 2'b00, 0);
    axi_write("wr_lbalo", 7'h08, 32'h89AB_CDEF, 4'hF, 2'b00, 0);
    axi_write("wr_lbahi", 7'h0C, 32'h0000_1234, 4'hF, 2'b00, 0);
    axi_read("rd_len", 7'h04, 32'h0000_1000, 2'b00, 0);
    axi_write("db1", 7'h10, 32'h0000_0201, 4'hF, 2'b00, 0);
    chk("db1_valid_at_bvalid", valid_at_b, 1);
    chk("head_ch", nfc_cmd_ch, 2);
    chk("head_opc", nfc_cmd_opcode, 16'h0030);
    chk("head_len", nfc_cmd_len, 24'h001000);
    chk("head_lba", nfc_cmd_lba, 48'h1234_89AB_CDEF);
    pop_one();
    chk("post_pop_valid", nfc_cmd_valid, 0);
    axi_read("fstat_pop", 7'h14, 32'h0000_0100, 2'b00, 0);

    // fill, overflow, W1C, drain in order
    axi_write("fill0", 7'h10, 32'h0000_0001, 4'hF, 2'b00, 0);
    axi_write("fill1", 7'h10, 32'h0000_0101, 4'hF, 2'b00, 0);
    axi_write("fill2", 7'h10, 32'h0000_0201, 4'hF, 2'b00, 0);
    axi_write("fill3", 7'h10, 32'h0000_0301, 4'hF, 2'b00, 0);
    axi_write("fill_ovf", 7'h10, 32'h0000_0001, 4'hF, 2'b10, 0);
    axi_read("fstat_full", 7'h14, 32'h0001_0204, 2'b00, 0);
    axi_write("ovf_w1c", 7'h14, 32'h0001_0000, 4'hF, 2'b00, 0);
    axi_read("fstat_w1c", 7'h14, 32'h0000_0204, 2'b00, 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain_ch%0d", i), nfc_cmd_ch, i[1:0]);
      pop_one();
    end
    axi_read("fstat_drained", 7'h14, 32'h0000_0100, 2'b00, 0);

    // rejected and ignored doorbells
    axi_write("db_badch", 7'h10, 32'h0000_0501, 4'hF, 2'b10, 0);
    chk("badch_valid", nfc_cmd_valid, 0);
    axi_write("db_bit0", 7'h10, 32'h0000_0200, 4'hF, 2'b00, 0);
    axi_write("db_strb", 7'h10, 32'h0000_0201, 4'h2, 2'b00, 0);
    axi_read("fstat_nopush", 7'h14, 32'h0000_0100, 2'b00, 0);

    // channel status shadows and unmapped / RO accesses
    o_sr = 32'h5AE0_0000; o_status = 8'b0111_0000;
    repeat (2) @(posedge clk); #1;
    axi_read("ch2_stat", 7'h48, 32'h0000_03E0, 2'b00, 0);
    axi_read("ch3_stat", 7'h4C, 32'h0000_015A, 2'b00, 0);
    axi_read("ch0_stat", 7'h40, 32'h0, 2'b00, 0);
    axi_read("ch4_unmapped", 7'h50, 32'hDEAD_BEEF, 2'b10, 0);
    axi_read("rd_0x30", 7'h30, 32'hDEAD_BEEF, 2'b10, 0);
    axi_write("wr_0x30", 7'h30, 32'h1234_5678, 4'hF, 2'b10, 0);
    axi_write("wr_ro_ch", 7'h40, 32'hFFFF_FFFF, 4'hF, 2'b00, 0);
    axi_read("rd_doorbell", 7'h10, 32'h0, 2'b00, 0);
`ifndef NFC_CMD_IRQ_EN
    axi_read("rd_0x18_unmapped", 7'h18, 32'hDEAD_BEEF, 2'b10, 0);
    axi_write("wr_0x1c_unmapped", 7'h1C, 32'h1, 4'hF, 2'b10, 0);
`endif

    // back-pressure on B and R
    axi_write("hold_b", 7'h00, 32'h0000_0030, 4'hF, 2'b00, 10);
    axi_read("hold_r", 7'h48, 32'h0000_03E0, 2'b00, 10);

    // byte strobes and unimplemented bits
    axi_write("strb_opc", 7'h00, 32'hFFFF_AB12, 4'h1, 2'b00, 0);
    axi_read("strb_opc_rd", 7'h00, 32'h0000_0012, 2'b00, 0);
    axi_write("strb_len", 7'h04, 32'hFFFF_FFFF, 4'hC, 2'b00, 0);
    axi_read("strb_len_rd", 7'h04, 32'h00FF_1000, 2'b00, 0);
    axi_write("lbahi_all", 7'h0C, 32'hFFFF_FFFF, 4'hF, 2'b00, 0);
    axi_read("lbahi_rd", 7'h0C, 32'h0000_FFFF, 2'b00, 0);

    // push and pop in the same cycle with one entry queued
    axi_write("pp_opcA", 7'h00, 32'h0000_00A1, 4'hF, 2'b00, 0);
    axi_write("pp_dbA", 7'h10, 32'h0000_0101, 4'hF, 2'b00, 0);
    axi_write("pp_opcB", 7'h00, 32'h0000_00B2, 4'hF, 2'b00, 0);
    chk("pp_headA", nfc_cmd_opcode, 16'h00A1);
    pop_on_push = 1'b1;
    axi_write("pp_dbB", 7'h10, 32'h0000_0301, 4'hF, 2'b00, 0);
    pop_on_push = 1'b0;
    chk("pp_headB_opc", nfc_cmd_opcode, 16'h00B2);
    chk("pp_headB_ch", nfc_cmd_ch, 3);
    axi_read("pp_fstat", 7'h14, 32'h0000_0001, 2'b00, 0);
    pop_one();
    axi_read("pp_fstat_empty", 7'h14, 32'h0000_0100, 2'b00, 0);

`ifdef NFC_CMD_IRQ_EN
    axi_write("irq_clr_all", 7'h18, 32'h0000_0003, 4'hF, 2'b00, 0);
    axi_read("irq_stat_clr", 7'h18, 32'h0, 2'b00, 0);
    axi_write("irq_mask", 7'h1C, 32'h0000_0001, 4'hF, 2'b00, 0);
    axi_read("irq_mask_rd", 7'h1C, 32'h0000_0001, 2'b00, 0);
    chk("irq_idle", irq, 0);
    axi_write("irq_db", 7'h10, 32'h0000_0001, 4'hF, 2'b00, 0);
    chk("irq_after_push", irq, 0);
    pop_one();
    chk("irq_after_pop", irq, 1);
    axi_read("irq_stat_pop", 7'h18, 32'h0000_0001, 2'b00, 0);
    axi_write("irq_w1c", 7'h18, 32'h0000_0001, 4'hF, 2'b00, 0);
    chk("irq_cleared", irq, 0);
`endif

    // asynchronous reset with two entries queued
    axi_write("rq_db0", 7'h10, 32'h0000_0001, 4'hF, 2'b00, 0);
    axi_write("rq_db1", 7'h10, 32'h0000_0101, 4'hF, 2'b00, 0);
    axi_read("rq_fstat", 7'h14, 32'h0000_0002, 2'b00, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", nfc_cmd_valid, 0);
    chk("arst_opcode", nfc_cmd_opcode, 0);
    chk("arst_lba", nfc_cmd_lba, 0);
`ifdef NFC_CMD_IRQ_EN
    chk("arst_irq", irq, 0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    axi_read("arst_fstat", 7'h14, 32'h0000_0100, 2'b00, 0);
    axi_read("arst_opc", 7'h00, 32'h0, 2'b00, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
